data_mem_ctrl: RTL

Parametrised byte-addressed data memory with a request/response handshake for the MEM stage. It generalises the word-only data memory with byte, half and word accesses, optional sign extension, configurable read latency, an address window with range and alignment checking, and an error response. Storage is big-endian: the lowest byte address holds the most-significant byte.

---
 rtl/data_mem_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory with req/ready handshake and fixed-latency response.
// Define MEM_CLEAR_EN to zero the storage one word per cycle after every reset.
module data_mem_ctrl #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned MEM_SIZE     = 1024,
  parameter int unsigned BASE_ADDR    = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] dataIn,
  output logic                 ready,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] dataOut,
  output logic                 err
);

  localparam int unsigned WB    = WORD_SIZE / 8;
  localparam int unsigned AW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int unsigned AddrW = WORD_SIZE + 1;
  localparam logic [AddrW-1:0] WinLo = AddrW'(BASE_ADDR);
  localparam logic [AddrW-1:0] WinHi = AddrW'(BASE_ADDR) + AddrW'(MEM_SIZE);
  localparam logic [2:0] CntLast = 3'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   data_q, data_d;
  logic                   err_q, err_d;

  logic [7:0]             mem [MEM_SIZE];

  logic                   accept;
  logic                   clear_busy, clear_we;
  logic [AW-1:0]          clear_base;
  logic [AddrW-1:0]       addr_ext, last_addr;
  logic                   size_ok, align_ok, range_ok, legal;
  logic [AW-1:0]          off_idx;
  logic [WORD_SIZE-1:0]   rd_word, ld_data;
  logic [7:0]             rd_byte;
  logic [15:0]            rd_half;

`ifdef MEM_CLEAR_EN
  localparam int unsigned NumWords = MEM_SIZE / WB;
  localparam int unsigned CW       = (NumWords > 1) ? $clog2(NumWords) : 1;

  logic [CW-1:0] clr_cnt_q;
  logic          clr_busy_q;

  // Any reset (including one during the clear) restarts from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_busy_q <= 1'b1;
      clr_cnt_q  <= '0;
    end else if (clr_busy_q) begin
      if (clr_cnt_q == CW'(NumWords - 1)) clr_busy_q <= 1'b0;
      clr_cnt_q <= clr_cnt_q + CW'(1);
    end
  end

  assign clear_busy = clr_busy_q;
  assign clear_we   = clr_busy_q && !rst;
  assign clear_base = AW'(clr_cnt_q * WB);
`else
  assign clear_busy = 1'b0;
  assign clear_we   = 1'b0;
  assign clear_base = '0;
`endif

  assign ready  = (state_q != StWait) && !clear_busy;
  assign accept = req && ready && !rst;

  // Legality: the extra address bit keeps last_addr from wrapping near the top of the space.
  assign addr_ext = {1'b0, address};
  always_comb begin
    size_ok   = 1'b1;
    align_ok  = 1'b1;
    last_addr = addr_ext + AddrW'(WB - 1);
    case (size)
      2'b00: last_addr = addr_ext;
      2'b01: begin
        last_addr = addr_ext + AddrW'(1);
        align_ok  = ~address[0];
      end
      2'b10: align_ok = (address[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
  end
  assign range_ok = (addr_ext >= WinLo) && (last_addr < WinHi);
  assign legal    = size_ok && align_ok && range_ok;
  assign off_idx  = AW'(address - WORD_SIZE'(BASE_ADDR));

  // Big-endian gather: lowest offset lands in the most-significant byte.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(WB); i++) begin
      rd_word[WORD_SIZE-1-8*i -: 8] = mem[off_idx + AW'(i)];
    end
  end
  assign rd_byte = rd_word[WORD_SIZE-1 -: 8];
  assign rd_half = rd_word[WORD_SIZE-1 -: 16];

  always_comb begin
    case (size)
      2'b00:   ld_data = sign_ext ? {{(WORD_SIZE-8){rd_byte[7]}}, rd_byte}
                                  : {{(WORD_SIZE-8){1'b0}}, rd_byte};
      2'b01:   ld_data = sign_ext ? {{(WORD_SIZE-16){rd_half[15]}}, rd_half}
                                  : {{(WORD_SIZE-16){1'b0}}, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      for (int i = 0; i < int'(WB); i++) mem[clear_base + AW'(i)] <= 8'h00;
    end else if (accept && we && legal) begin
      case (size)
        2'b00: mem[off_idx] <= dataIn[7:0];
        2'b01: begin
          mem[off_idx]          <= dataIn[15:8];
          mem[off_idx + AW'(1)] <= dataIn[7:0];
        end
        default: begin
          for (int i = 0; i < int'(WB); i++) begin
            mem[off_idx + AW'(i)] <= dataIn[WORD_SIZE-1-8*i -: 8];
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      StWait: begin
        if (cnt_q == CntLast) state_d = StResp;
        else                  cnt_d   = cnt_q + 3'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = state_q;
    endcase
    // Acceptance is possible from both Idle and Resp and overrides the above.
    if (accept) begin
      state_d = (READ_LATENCY == 1) ? StResp : StWait;
      cnt_d   = '0;
      err_d   = !legal;
      data_d  = (legal && !we) ? ld_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == StResp);
  assign dataOut    = resp_valid ? data_q : '0;
  assign err        = resp_valid && err_q;

endmodule
